// File: rtl/hazard_pipe_ctrl.sv
// Pipeline control-field carrier from ID to WB. It detects load-use hazards,
// generates stall and flush, drains and freezes on HLT, and counts load-use stalls.
module hazard_pipe_ctrl #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_ID,
  input  logic [ADDR_W-1:0] p0_addr_ID,
  input  logic [ADDR_W-1:0] p1_addr_ID,
  input  logic              p0_used_ID,
  input  logic              p1_used_ID,
  input  logic [ADDR_W-1:0] dst_addr_ID,
  input  logic              we_rf_ID,
  input  logic              re_mem_ID,
  input  logic              hlt_ID,
  input  logic              flush_EX,
  output logic              stall_IF_ID,
  output logic              flush_IF_ID,
  output logic [ADDR_W-1:0] p0_addr_EX,
  output logic [ADDR_W-1:0] p1_addr_EX,
  output logic              we_rf_EX,
  output logic              re_mem_EX,
  output logic [ADDR_W-1:0] dst_addr_EX,
  output logic              we_rf_MEM,
  output logic              re_mem_MEM,
  output logic [ADDR_W-1:0] dst_addr_MEM,
  output logic              we_rf_WB,
  output logic [ADDR_W-1:0] dst_addr_WB,
  output logic              hlt_WB,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] p0;
    logic [ADDR_W-1:0] p1;
    logic [ADDR_W-1:0] dst;
    logic              we;
    logic              re;
    logic              hlt;
  } ex_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic              we;
    logic              re;
    logic              hlt;
  } mem_t;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic              we;
    logic              hlt;
  } wb_t;

  state_e           state_q, state_d;
  ex_t              ex_q, ex_d;
  mem_t             mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu, move_id;

  always_comb begin
    lu = vld_ID & ex_q.re & ex_q.we & (ex_q.dst != '0) &
         ((p0_used_ID & (p0_addr_ID == ex_q.dst)) |
          (p1_used_ID & (p1_addr_ID == ex_q.dst)));
    // Only RUN admits new work into EX; DRAIN and HALTED feed bubbles.
    move_id = vld_ID & ~lu & ~flush_EX & (state_q == RUN);

    state_d     = state_q;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;

    if (state_q != HALTED) begin
      wb_d  = '{dst: mem_q.dst, we: mem_q.we, hlt: mem_q.hlt};
      mem_d = '{dst: ex_q.dst, we: ex_q.we, re: ex_q.re, hlt: ex_q.hlt};
      ex_d  = '0;
      if (move_id)
        ex_d = '{p0: p0_addr_ID, p1: p1_addr_ID, dst: dst_addr_ID,
                 we: we_rf_ID, re: re_mem_ID, hlt: hlt_ID};
      if (lu && !flush_EX && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      RUN:     if (move_id && hlt_ID) state_d = DRAIN;
      DRAIN:   if (mem_q.hlt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    stall_IF_ID = (lu & ~flush_EX) | (state_q != RUN);
    flush_IF_ID = flush_EX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign p0_addr_EX   = ex_q.p0;
  assign p1_addr_EX   = ex_q.p1;
  assign we_rf_EX     = ex_q.we;
  assign re_mem_EX    = ex_q.re;
  assign dst_addr_EX  = ex_q.dst;
  assign we_rf_MEM    = mem_q.we;
  assign re_mem_MEM   = mem_q.re;
  assign dst_addr_MEM = mem_q.dst;
  assign we_rf_WB     = wb_q.we;
  assign dst_addr_WB  = wb_q.dst;
  assign hlt_WB       = wb_q.hlt;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl. It runs directed vectors, halt and saturation sequences,
// then random traffic against a stage-content reference model.
module tb_hazard_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, vld_ID, p0_used_ID, p1_used_ID, we_rf_ID, re_mem_ID, hlt_ID, flush_EX;
  logic [3:0] p0_addr_ID, p1_addr_ID, dst_addr_ID;

  logic       stall, flush, we_ex, re_ex, we_mem, re_mem, we_wb, hlt_wb;
  logic [3:0] p0_ex, p1_ex, dst_ex, dst_mem, dst_wb;
  logic [15:0] cnt;
  logic       s_stall, s_flush, s_we_ex, s_re_ex, s_we_mem, s_re_mem, s_we_wb, s_hlt_wb;
  logic [3:0] s_p0_ex, s_p1_ex, s_dst_ex, s_dst_mem, s_dst_wb;
  logic [1:0] s_cnt;

  hazard_pipe_ctrl #(.ADDR_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .vld_ID(vld_ID), .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .p0_used_ID(p0_used_ID), .p1_used_ID(p1_used_ID), .dst_addr_ID(dst_addr_ID),
    .we_rf_ID(we_rf_ID), .re_mem_ID(re_mem_ID), .hlt_ID(hlt_ID), .flush_EX(flush_EX),
    .stall_IF_ID(stall), .flush_IF_ID(flush), .p0_addr_EX(p0_ex), .p1_addr_EX(p1_ex),
    .we_rf_EX(we_ex), .re_mem_EX(re_ex), .dst_addr_EX(dst_ex), .we_rf_MEM(we_mem),
    .re_mem_MEM(re_mem), .dst_addr_MEM(dst_mem), .we_rf_WB(we_wb), .dst_addr_WB(dst_wb),
    .hlt_WB(hlt_wb), .stall_cnt(cnt));

  hazard_pipe_ctrl #(.ADDR_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .vld_ID(vld_ID), .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .p0_used_ID(p0_used_ID), .p1_used_ID(p1_used_ID), .dst_addr_ID(dst_addr_ID),
    .we_rf_ID(we_rf_ID), .re_mem_ID(re_mem_ID), .hlt_ID(hlt_ID), .flush_EX(flush_EX),
    .stall_IF_ID(s_stall), .flush_IF_ID(s_flush), .p0_addr_EX(s_p0_ex), .p1_addr_EX(s_p1_ex),
    .we_rf_EX(s_we_ex), .re_mem_EX(s_re_ex), .dst_addr_EX(s_dst_ex), .we_rf_MEM(s_we_mem),
    .re_mem_MEM(s_re_mem), .dst_addr_MEM(s_dst_mem), .we_rf_WB(s_we_wb), .dst_addr_WB(s_dst_wb),
    .hlt_WB(s_hlt_wb), .stall_cnt(s_cnt));

  logic [27:0] obs_main, obs_sat;
  assign obs_main = {stall, flush, p0_ex, p1_ex, we_ex, re_ex, dst_ex,
                     we_mem, re_mem, dst_mem, we_wb, dst_wb, hlt_wb};
  assign obs_sat  = {s_stall, s_flush, s_p0_ex, s_p1_ex, s_we_ex, s_re_ex, s_dst_ex,
                     s_we_mem, s_re_mem, s_dst_mem, s_we_wb, s_dst_wb, s_hlt_wb};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents of each stage as plain records.
  typedef struct {
    logic [3:0] p0, p1, dst;
    logic       we, re, hlt;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_cnt;

  function automatic logic model_lu();
    return vld_ID && m_ex.re && m_ex.we && m_ex.dst != 0 &&
           ((p0_used_ID && p0_addr_ID == m_ex.dst) || (p1_used_ID && p1_addr_ID == m_ex.dst));
  endfunction

  function automatic logic [27:0] model_obs();
    logic st;
    st = m_wb.hlt || m_ex.hlt || m_mem.hlt || (model_lu() && !flush_EX);
    return {st, flush_EX, m_ex.p0, m_ex.p1, m_ex.we, m_ex.re, m_ex.dst,
            m_mem.we, m_mem.re, m_mem.dst, m_wb.we, m_wb.dst, m_wb.hlt};
  endfunction

  // Called at negedge+1 with inputs applied; returns at the next negedge.
  task automatic step();
    logic lu_m, drain;
    ins_t bub;
    bub = '{default: '0};
    check("obs_main", 32'(obs_main), 32'(model_obs()));
    check("obs_sat", 32'(obs_sat), 32'(model_obs()));
    check("cnt", 32'(cnt), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    check("cnt_sat", 32'(s_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
    lu_m  = model_lu();
    drain = m_ex.hlt || m_mem.hlt;
    @(posedge clk);
    if (rst) begin
      m_ex = bub; m_mem = bub; m_wb = bub; m_cnt = 0;
    end else if (!m_wb.hlt) begin
      if (lu_m && !flush_EX) m_cnt++;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (vld_ID && !lu_m && !flush_EX && !drain)
        m_ex = '{p0_addr_ID, p1_addr_ID, dst_addr_ID, we_rf_ID, re_mem_ID, hlt_ID};
      else
        m_ex = bub;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    vld_ID = 0; p0_addr_ID = 0; p1_addr_ID = 0; p0_used_ID = 0; p1_used_ID = 0;
    dst_addr_ID = 0; we_rf_ID = 0; re_mem_ID = 0; hlt_ID = 0; flush_EX = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_in(); #1; step(); rst = 0;
  endtask

  typedef struct {
    logic       vld, u0, u1, we, re, hlt, fl;
    logic [3:0] p0, p1, dst;
    logic       e_stall, e_flush, e_wewb;
    logic [3:0] e_dex, e_dmem, e_dwb;
    int         e_cnt;
  } vec_t;

  function automatic vec_t mk(logic vld, logic [3:0] p0, logic u0, logic [3:0] p1, logic u1,
                              logic [3:0] dst, logic we, logic re, logic hlt, logic fl,
                              logic es, logic ef, logic [3:0] edx, logic [3:0] edm,
                              logic [3:0] edw, logic eww, int ec);
    vec_t v;
    v.vld = vld; v.p0 = p0; v.u0 = u0; v.p1 = p1; v.u1 = u1; v.dst = dst;
    v.we = we; v.re = re; v.hlt = hlt; v.fl = fl;
    v.e_stall = es; v.e_flush = ef; v.e_dex = edx; v.e_dmem = edm; v.e_dwb = edw;
    v.e_wewb = eww; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[14];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    // load-use stall, field propagation, no-false-stall, stall/flush collision
    tbl[0]  = mk(1, 0,0, 0,0, 3, 1,1,0,0,  0,0, 0,0,0,0, 0);
    tbl[1]  = mk(1, 0,0, 3,1, 4, 1,0,0,0,  1,0, 3,0,0,0, 0);
    tbl[2]  = mk(1, 0,0, 3,1, 4, 1,0,0,0,  0,0, 0,3,0,0, 1);
    tbl[3]  = mk(1, 5,1, 0,0, 7, 1,0,0,0,  0,0, 4,0,3,1, 1);
    tbl[4]  = mk(0, 0,0, 0,0, 0, 0,0,0,0,  0,0, 7,4,0,0, 1);
    tbl[5]  = mk(0, 0,0, 0,0, 0, 0,0,0,0,  0,0, 0,7,4,1, 1);
    tbl[6]  = mk(0, 0,0, 0,0, 0, 0,0,0,0,  0,0, 0,0,7,1, 1);
    tbl[7]  = mk(1, 0,0, 0,0, 0, 1,1,0,0,  0,0, 0,0,0,0, 1);
    tbl[8]  = mk(1, 0,1, 0,0, 0, 0,0,0,0,  0,0, 0,0,0,0, 1);
    tbl[9]  = mk(1, 0,0, 0,0, 5, 1,0,0,0,  0,0, 0,0,0,0, 1);
    tbl[10] = mk(1, 5,1, 0,0, 0, 0,0,0,0,  0,0, 5,0,0,1, 1);
    tbl[11] = mk(1, 0,0, 0,0, 6, 1,1,0,0,  0,0, 0,5,0,0, 1);
    tbl[12] = mk(1, 6,1, 0,0, 2, 1,0,0,1,  0,1, 6,0,5,1, 1);
    tbl[13] = mk(0, 0,0, 0,0, 0, 0,0,0,0,  0,0, 0,6,0,0, 1);

    // First reset: DUT state is unknown, so only the model is cleared here.
    rst = 1; idle_in();
    @(posedge clk);
    m_ex = '{default: '0}; m_mem = '{default: '0}; m_wb = '{default: '0}; m_cnt = 0;
    @(negedge clk);
    rst = 0; #1;
    check("reset_obs", 32'(obs_main), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    step();

    foreach (tbl[i]) begin
      vld_ID = tbl[i].vld; p0_addr_ID = tbl[i].p0; p0_used_ID = tbl[i].u0;
      p1_addr_ID = tbl[i].p1; p1_used_ID = tbl[i].u1; dst_addr_ID = tbl[i].dst;
      we_rf_ID = tbl[i].we; re_mem_ID = tbl[i].re; hlt_ID = tbl[i].hlt; flush_EX = tbl[i].fl;
      #1;
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      check($sformatf("vec%0d_dst_ex", i), 32'(dst_ex), 32'(tbl[i].e_dex));
      check($sformatf("vec%0d_dst_mem", i), 32'(dst_mem), 32'(tbl[i].e_dmem));
      check($sformatf("vec%0d_dst_wb", i), 32'(dst_wb), 32'(tbl[i].e_dwb));
      check($sformatf("vec%0d_we_wb", i), 32'(we_wb), 32'(tbl[i].e_wewb));
      check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
      step();
    end

    // Back-to-back dependent loads: hazards on every other cycle.
    do_reset();
    vld_ID = 1; re_mem_ID = 1; we_rf_ID = 1; dst_addr_ID = 1; p0_addr_ID = 1; p0_used_ID = 1;
    for (int k = 0; k < 10; k++) begin
      #1; step();
      if (k % 2 == 1) begin
        check("sat_cnt", 32'(s_cnt), 32'(sat_exp[k/2]));
        check("sat_cnt_main", 32'(cnt), 32'((k + 1) / 2));
      end
    end

    // Halt drain and freeze.
    do_reset();
    vld_ID = 1; hlt_ID = 1; #1; step();
    for (int j = 1; j <= 13; j++) begin
      vld_ID = 1'($urandom); p0_addr_ID = 4'($urandom); p1_addr_ID = 4'($urandom);
      p0_used_ID = 1'($urandom); p1_used_ID = 1'($urandom); dst_addr_ID = 4'($urandom);
      we_rf_ID = 1'($urandom); re_mem_ID = 1'($urandom); hlt_ID = 1'($urandom);
      flush_EX = (j >= 3) ? 1'($urandom) : 1'b0;
      #1;
      check("halt_stall", 32'(stall), 32'd1);
      check("halt_wb", 32'(hlt_wb), 32'(j >= 3));
      step();
    end
    rst = 1; idle_in(); #1; step(); rst = 0; #1;
    check("halt_reset_wb", 32'(hlt_wb), 32'd0);
    check("halt_reset_stall", 32'(stall), 32'd0);
    step();

    // HLT killed by a coincident flush.
    vld_ID = 1; hlt_ID = 1; flush_EX = 1; #1; step();
    idle_in();
    for (int j = 0; j < 5; j++) begin
      #1;
      check("flush_hlt_wb", 32'(hlt_wb), 32'd0);
      check("flush_hlt_stall", 32'(stall), 32'd0);
      step();
    end

    // Random traffic; small address range keeps hazards frequent.
    begin
      int halted_cyc = 0;
      for (int n = 0; n < 3000; n++) begin
        rst = ($urandom_range(99) == 0) || (halted_cyc > 4);
        vld_ID = ($urandom_range(3) != 0);
        p0_addr_ID = 4'($urandom_range(3)); p1_addr_ID = 4'($urandom_range(3));
        p0_used_ID = 1'($urandom); p1_used_ID = 1'($urandom);
        dst_addr_ID = 4'($urandom_range(3));
        we_rf_ID = ($urandom_range(3) != 0); re_mem_ID = 1'($urandom);
        hlt_ID = ($urandom_range(59) == 0); flush_EX = ($urandom_range(9) == 0);
        #1; step();
        halted_cyc = m_wb.hlt ? halted_cyc + 1 : 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
